// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline stage register: stall-vector driven hold/bubble/advance,
// synchronous flush, zeroed payloads on invalid lanes, saturating bubble counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 72,
  parameter int unsigned N_LANES = 2,
  parameter int unsigned N_STALL = 6,
  parameter int unsigned STAGE   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_STALL-1:0]        i_stall,
  input  logic                      i_flush,
  input  logic                      i_cnt_clr,
  input  logic [N_LANES-1:0]        i_valid,
  input  logic [N_LANES*DATA_W-1:0] i_data,
  output logic [N_LANES-1:0]        o_valid,
  output logic [N_LANES*DATA_W-1:0] o_data,
  output logic                      o_hold,
  output logic [CNT_W-1:0]          o_bubble_cnt
);

  localparam int unsigned BUS_W  = N_LANES * DATA_W;
  localparam int unsigned SEL_W  = (N_STALL > 1) ? $clog2(N_STALL) : 1;
  localparam bit          HAS_DN = (STAGE + 1 < N_STALL);
  localparam int unsigned DN_IDX = HAS_DN ? STAGE + 1 : STAGE;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              up_stop_c;
  logic              dn_stop_c;
  logic [BUS_W-1:0]  adv_data_c;
  logic [N_LANES-1:0] valid_nxt_c;
  logic [BUS_W-1:0]  data_nxt_c;
  logic              hold_nxt_c;
  logic [CNT_W-1:0]  cnt_nxt_c;

  // The last stage has no downstream stage in the vector, so it never sees a hold.
  assign up_stop_c = i_stall[SEL_W'(STAGE)];
  assign dn_stop_c = HAS_DN ? i_stall[SEL_W'(DN_IDX)] : 1'b0;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign adv_data_c[k*DATA_W +: DATA_W] = i_valid[k] ? i_data[k*DATA_W +: DATA_W] : '0;
  end

  // Branch selection in priority order: flush, bubble, advance, hold.
  always_comb begin
    valid_nxt_c = o_valid;
    data_nxt_c  = o_data;
    hold_nxt_c  = 1'b0;
    cnt_nxt_c   = o_bubble_cnt;
    if (i_flush) begin
      valid_nxt_c = '0;
      data_nxt_c  = '0;
    end else if (up_stop_c && !dn_stop_c) begin
      valid_nxt_c = '0;
      data_nxt_c  = '0;
      if (o_bubble_cnt != CNT_MAX) begin
        cnt_nxt_c = o_bubble_cnt + CNT_W'(1);
      end
    end else if (!up_stop_c) begin
      valid_nxt_c = i_valid;
      data_nxt_c  = adv_data_c;
    end else begin
      hold_nxt_c = 1'b1;
    end
    if (i_cnt_clr) begin
      cnt_nxt_c = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= '0;
      o_data       <= '0;
      o_hold       <= 1'b0;
      o_bubble_cnt <= '0;
    end else begin
      o_valid      <= valid_nxt_c;
      o_data       <= data_nxt_c;
      o_hold       <= hold_nxt_c;
      o_bubble_cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table on a 2-lane STAGE=4 build,
// random stall sequence on a scalar STAGE=5 build against a behavioural model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: 2 lanes x 72 bits, STAGE 4, 4-bit counter
  logic [5:0]   a_stall;
  logic         a_flush, a_clr;
  logic [1:0]   a_valid;
  logic [143:0] a_data;
  logic [1:0]   a_o_valid;
  logic [143:0] a_o_data;
  logic         a_o_hold;
  logic [3:0]   a_o_cnt;

  pipe_stage_reg #(.DATA_W(72), .N_LANES(2), .N_STALL(6), .STAGE(4), .CNT_W(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(a_stall), .i_flush(a_flush),
    .i_cnt_clr(a_clr), .i_valid(a_valid), .i_data(a_data),
    .o_valid(a_o_valid), .o_data(a_o_data), .o_hold(a_o_hold), .o_bubble_cnt(a_o_cnt)
  );

  // Instance B: scalar 38-bit MEM/WB, upstream stage is the last in the vector
  logic [5:0]  b_stall;
  logic        b_flush, b_clr;
  logic [0:0]  b_valid;
  logic [37:0] b_data;
  logic [0:0]  b_o_valid;
  logic [37:0] b_o_data;
  logic        b_o_hold;
  logic [15:0] b_o_cnt;

  pipe_stage_reg #(.DATA_W(38), .N_LANES(1), .N_STALL(6), .STAGE(5), .CNT_W(16)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(b_stall), .i_flush(b_flush),
    .i_cnt_clr(b_clr), .i_valid(b_valid), .i_data(b_data),
    .o_valid(b_o_valid), .o_data(b_o_data), .o_hold(b_o_hold), .o_bubble_cnt(b_o_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stimulus never drives the illegal advance-under-downstream-stop pattern on A
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(!a_stall[4] && a_stall[5]))
        else $error("FAIL illegal_stall: stall=%b", a_stall);
    end
  end

  typedef struct {
    logic [5:0]   stall;
    logic         flush;
    logic         clr;
    logic [1:0]   valid;
    logic [143:0] data;
    logic [1:0]   e_valid;
    logic [143:0] e_data;
    logic         e_hold;
    logic [3:0]   e_cnt;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [5:0] s, input logic f, input logic c,
                              input logic [1:0] v, input logic [143:0] d,
                              input logic [1:0] ev, input logic [143:0] ed,
                              input logic eh, input logic [3:0] ec);
    vec_t r;
    r.stall = s; r.flush = f; r.clr = c; r.valid = v; r.data = d;
    r.e_valid = ev; r.e_data = ed; r.e_hold = eh; r.e_cnt = ec;
    return r;
  endfunction

  // Scalar reference model state
  logic        m_valid;
  logic [37:0] m_data;
  logic        m_hold;
  int          m_cnt;

  task automatic model_step();
    logic up, dn, bubble;
    up = b_stall[5];
    dn = 1'b0;  // no stage after the last one
    bubble = !b_flush && up && !dn;
    if (b_flush || bubble) begin
      m_valid = 1'b0; m_data = '0; m_hold = 1'b0;
    end else if (!up) begin
      m_valid = b_valid[0]; m_data = b_valid[0] ? b_data : 38'd0; m_hold = 1'b0;
    end else begin
      m_hold = 1'b1;
    end
    if (b_clr) m_cnt = 0;
    else if (bubble) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
  endtask

  initial begin
    logic [71:0]  ones72;
    logic [143:0] z144;
    ones72 = '1;
    z144 = '0;

    a_stall = '0; a_flush = 0; a_clr = 0; a_valid = 2'b11; a_data = {ones72, ones72};
    b_stall = '0; b_flush = 0; b_clr = 0; b_valid = '0; b_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 144'(a_o_valid), 144'(0));
    chk("rst_async_data", a_o_data, z144);
    chk("rst_async_cnt", 144'(a_o_cnt), 144'(0));
    chk("rst_async_hold", 144'(a_o_hold), 144'(0));
    repeat (2) @(posedge clk);
    #1 chk("rst_clocked_valid", 144'(a_o_valid), 144'(0));
    @(negedge clk) rst_n = 1'b1;

    vecs[0]  = mk(6'b000000, 0, 0, 2'b01, {ones72, 72'h12_3456_789A},
                  2'b01, {72'h0, 72'h12_3456_789A}, 0, 4'd0);
    vecs[1]  = mk(6'b010000, 0, 0, 2'b11, {ones72, ones72}, 2'b00, z144, 0, 4'd1);
    vecs[2]  = mk(6'b000000, 0, 0, 2'b11, {72'hAB, 72'hCD}, 2'b11, {72'hAB, 72'hCD}, 0, 4'd1);
    vecs[3]  = mk(6'b110000, 0, 0, 2'b00, {72'h1, 72'h2}, 2'b11, {72'hAB, 72'hCD}, 1, 4'd1);
    vecs[4]  = mk(6'b110000, 0, 0, 2'b01, {72'h3, 72'h4}, 2'b11, {72'hAB, 72'hCD}, 1, 4'd1);
    vecs[5]  = mk(6'b110000, 0, 0, 2'b10, {72'h5, 72'h6}, 2'b11, {72'hAB, 72'hCD}, 1, 4'd1);
    vecs[6]  = mk(6'b000000, 0, 0, 2'b10, {72'h55, 72'h66}, 2'b10, {72'h55, 72'h0}, 0, 4'd1);
    vecs[7]  = mk(6'b110000, 0, 0, 2'b01, {72'h7, 72'h8}, 2'b10, {72'h55, 72'h0}, 1, 4'd1);
    vecs[8]  = mk(6'b110000, 1, 0, 2'b11, {72'h9, 72'hA}, 2'b00, z144, 0, 4'd1);
    vecs[9]  = mk(6'b010000, 1, 0, 2'b11, {72'hB, 72'hC}, 2'b00, z144, 0, 4'd1);
    vecs[10] = mk(6'b000000, 0, 0, 2'b11, {72'hA1, 72'hB2}, 2'b11, {72'hA1, 72'hB2}, 0, 4'd1);
    vecs[11] = mk(6'b010000, 0, 1, 2'b11, {72'hE, 72'hF}, 2'b00, z144, 0, 4'd0);
    vecs[12] = mk(6'b000000, 0, 0, 2'b11, {72'hC3, 72'hD4}, 2'b11, {72'hC3, 72'hD4}, 0, 4'd0);
    vecs[13] = mk(6'b111111, 0, 0, 2'b00, {72'h11, 72'h22}, 2'b11, {72'hC3, 72'hD4}, 1, 4'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_stall = vecs[i].stall; a_flush = vecs[i].flush; a_clr = vecs[i].clr;
      a_valid = vecs[i].valid; a_data = vecs[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", i), 144'(a_o_valid), 144'(vecs[i].e_valid));
      chk($sformatf("row%0d_data", i), a_o_data, vecs[i].e_data);
      chk($sformatf("row%0d_hold", i), 144'(a_o_hold), 144'(vecs[i].e_hold));
      chk($sformatf("row%0d_cnt", i), 144'(a_o_cnt), 144'(vecs[i].e_cnt));
    end

    // Counter saturation: 20 consecutive bubbles on a 4-bit counter
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      a_stall = 6'b010000; a_flush = 0; a_clr = 0; a_valid = 2'b11;
      @(posedge clk);
      #1 chk($sformatf("sat_cnt%0d", i), 144'(a_o_cnt), 144'((i < 15) ? i : 15));
    end
    @(negedge clk) a_clr = 1'b1;
    @(posedge clk);
    #1 chk("clr_with_bubble", 144'(a_o_cnt), 144'(0));

    // Reset in the middle of a bubble run discards the count immediately
    @(negedge clk) a_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_cnt", 144'(a_o_cnt), 144'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cnt", 144'(a_o_cnt), 144'(0));
    chk("midrst_valid", 144'(a_o_valid), 144'(0));
    chk("midrst_b_valid", 144'(b_o_valid), 144'(0));
    @(negedge clk);
    rst_n = 1'b1;
    a_stall = '0; a_valid = '0;
    m_valid = 1'b0; m_data = '0; m_hold = 1'b0; m_cnt = 0;

    // Boundary at the last stage: top stall bit alone is a bubble, not a hold
    b_stall = 6'b100000; b_valid = 1'b1; b_data = 38'h12_3456_789A;
    model_step();
    @(posedge clk);
    #1;
    chk("last_stage_valid", 144'(b_o_valid), 144'(0));
    chk("last_stage_hold", 144'(b_o_hold), 144'(0));
    chk("last_stage_cnt", 144'(b_o_cnt), 144'(1));

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      b_stall = 6'($urandom);
      b_flush = ($urandom_range(15) == 0);
      b_clr   = ($urandom_range(31) == 0);
      b_valid = 1'($urandom);
      b_data  = {6'($urandom), 32'($urandom)};
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_valid", i), 144'(b_o_valid), 144'(m_valid));
      chk($sformatf("rnd%0d_data", i), 144'(b_o_data), 144'(m_data));
      chk($sformatf("rnd%0d_hold", i), 144'(b_o_hold), 144'(m_hold));
      chk($sformatf("rnd%0d_cnt", i), 144'(b_o_cnt), 144'(m_cnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
